// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - handshake and payload bundle for the ALU execute stage
// Purpose: groups the upstream (op in) and downstream (result out) channels.
// Ports (slave view, as seen by alu_exec_stage):
//   in : InValid, ALUCtrl[3:0], BusA[WIDTH], BusB[WIDTH], OutReady
//   out: InReady, OutValid, ALUResult[WIDTH], Zero, Negative, Carry, Overflow, IllegalOp
interface alu_exec_stage_if #(
    parameter int WIDTH = 64
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             IllegalOp;

    modport master (
        output InValid, ALUCtrl, BusA, BusB, OutReady,
        input  InReady, OutValid, ALUResult, Zero, Negative, Carry, Overflow, IllegalOp
    );

    modport slave (
        input  InValid, ALUCtrl, BusA, BusB, OutReady,
        output InReady, OutValid, ALUResult, Zero, Negative, Carry, Overflow, IllegalOp
    );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU execute stage with one-entry skid buffer
// Purpose: computes result + NZCV + IllegalOp at accept time and presents them one
//          cycle later; OR (output register) and SK (skid register) form a 2-deep FIFO.
// Ports:
//   CLK   - clock, rising edge
//   Reset - asynchronous, active-high
//   bus   - alu_exec_stage_if.slave (op channel in, result channel out)
module alu_exec_stage #(
    parameter int WIDTH = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    alu_exec_stage_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    // Entry layout: {ill, n, z, c, v, result}
    localparam int PW  = WIDTH + 5;
    localparam int MSB = WIDTH - 1;

    logic [PW-1:0]    r_or_data;
    logic             r_or_valid;
    logic [PW-1:0]    r_sk_data;
    logic             r_sk_valid;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_ill;
    logic [PW-1:0]    w_entry;
    logic             w_accept;
    logic             w_or_free;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (bus.ALUCtrl)
            OP_ADD: begin
                w_sum = {1'b0, bus.BusA} + {1'b0, bus.BusB};
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.BusA[MSB] == bus.BusB[MSB]) && (w_res[MSB] != bus.BusA[MSB]);
            end
            OP_SUB: begin
                // Two's-complement subtract; carry-out set means no borrow.
                w_sum = {1'b0, bus.BusA} + {1'b0, ~bus.BusB} + (WIDTH+1)'(1);
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.BusA[MSB] != bus.BusB[MSB]) && (w_res[MSB] != bus.BusA[MSB]);
            end
            OP_AND:  w_res = bus.BusA & bus.BusB;
            OP_ORR:  w_res = bus.BusA | bus.BusB;
            OP_PASS: w_res = bus.BusB;
            default: w_ill = 1'b1;
        endcase
    end

    assign w_entry   = {w_ill, w_res[MSB], (w_res == '0), w_c, w_v, w_res};
    // InReady depends only on r_sk_valid, so no OutReady->InReady combinational path.
    assign w_accept  = bus.InValid && !r_sk_valid;
    assign w_or_free = !r_or_valid || bus.OutReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
        end else if (w_or_free) begin
            if (r_sk_valid) begin
                // Skid drains first to keep FIFO order; no accept possible this cycle.
                r_or_data  <= r_sk_data;
                r_or_valid <= 1'b1;
                r_sk_valid <= 1'b0;
            end else if (w_accept) begin
                r_or_data  <= w_entry;
                r_or_valid <= 1'b1;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // OR held by backpressure: park the new op in the skid slot.
            r_sk_data  <= w_entry;
            r_sk_valid <= 1'b1;
        end
    end

    assign bus.InReady   = !r_sk_valid;
    assign bus.OutValid  = r_or_valid;
    assign bus.ALUResult = r_or_data[MSB:0];
    assign bus.Overflow  = r_or_data[WIDTH];
    assign bus.Carry     = r_or_data[WIDTH+1];
    assign bus.Zero      = r_or_data[WIDTH+2];
    assign bus.Negative  = r_or_data[WIDTH+3];
    assign bus.IllegalOp = r_or_data[WIDTH+4];
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
    localparam int W = 64;
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_ORR  = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_PASS = 4'b0111;

    logic CLK;
    logic Reset;
    alu_exec_stage_if #(.WIDTH(W)) vif ();

    alu_exec_stage #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (vif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [W+4:0] sb[$];
    logic [W-1:0] out_log[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: mathematical meaning of each op; {ill, n, z, c, v, result}.
    function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic c, v, ill;
        logic signed [W+1:0] exact;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            C_ADD: begin
                r = a + b;
                c = ({2'b00, a} + {2'b00, b}) > {2'b00, {W{1'b1}}};
                exact = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
                v = (exact != $signed({{2{r[W-1]}}, r}));
            end
            C_SUB: begin
                r = a - b;
                c = (a >= b);
                exact = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
                v = (exact != $signed({{2{r[W-1]}}, r}));
            end
            C_AND:  r = a & b;
            C_ORR:  r = a | b;
            C_PASS: r = b;
            default: ill = 1'b1;
        endcase
        return {ill, r[W-1], (r == 0), c, v, r};
    endfunction

    function automatic logic [W+4:0] observed();
        return {vif.IllegalOp, vif.Negative, vif.Zero, vif.Carry, vif.Overflow, vif.ALUResult};
    endfunction

    // One cycle: drive after the falling edge, then record what the next rising edge does.
    task automatic step(input logic iv, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, output logic acc, output logic xf);
        logic [W+4:0] e;
        @(negedge CLK);
        vif.InValid  = iv;
        vif.ALUCtrl  = op;
        vif.BusA     = a;
        vif.BusB     = b;
        vif.OutReady = ordy;
        #1;
        acc = iv && vif.InReady;
        xf  = vif.OutValid && ordy;
        if (xf) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("sb_payload", observed(), e);
                out_log.push_back(vif.ALUResult);
            end
        end
        if (acc) sb.push_back(model(op, a, b));
    endtask

    task automatic directed(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] er, input logic [4:0] ef);
        logic acc, xf;
        step(1'b1, op, a, b, 1'b1, acc, xf);
        chk({tag, "_acc"}, acc, 1'b1);
        step(1'b0, 4'b0, '0, '0, 1'b1, acc, xf);
        chk({tag, "_valid"}, vif.OutValid, 1'b1);
        chk({tag, "_res"}, vif.ALUResult, er);
        chk({tag, "_flags"}, {vif.IllegalOp, vif.Negative, vif.Zero, vif.Carry, vif.Overflow}, ef);
    endtask

    initial begin
        logic acc, xf;
        logic op3_done;
        int n_acc, n_x;
        logic [3:0] legal [5];
        legal[0] = C_ADD; legal[1] = C_SUB; legal[2] = C_AND; legal[3] = C_ORR; legal[4] = C_PASS;

        Reset = 1'b1;
        vif.InValid = 1'b0; vif.ALUCtrl = '0; vif.BusA = '0; vif.BusB = '0; vif.OutReady = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_outvalid", vif.OutValid, 1'b0);
        chk("rst_inready", vif.InReady, 1'b1);
        chk("rst_payload", observed(), '0);
        @(negedge CLK);
        Reset = 1'b0;

        // Directed arithmetic corners: flags packed {ill, n, z, c, v}.
        directed("add_ovf", C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 5'b01001);
        directed("sub_eq", C_SUB, 64'd5, 64'd5, 64'd0, 5'b00110);
        directed("sub_neg", C_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 5'b01000);
        directed("pass_zero", C_PASS, 64'h1234, 64'd0, 64'd0, 5'b00100);
        directed("and_zero", C_AND, 64'hF0, 64'h0F, 64'd0, 5'b00100);
        directed("orr_ff", C_ORR, 64'hF0, 64'h0F, 64'hFF, 5'b00000);
        directed("illegal", 4'b1111, 64'hDEAD, 64'hBEEF, 64'd0, 5'b10100);

        // Backpressure: op1 -> OR, op2 -> SK, op3 stalls.
        out_log.delete();
        step(1'b1, C_PASS, '0, 64'd1, 1'b0, acc, xf);
        chk("bp_acc1", acc, 1'b1);
        step(1'b1, C_PASS, '0, 64'd2, 1'b0, acc, xf);
        chk("bp_acc2", acc, 1'b1);
        step(1'b1, C_PASS, '0, 64'd3, 1'b0, acc, xf);
        chk("bp_acc3_stall", acc, 1'b0);
        chk("bp_inready", vif.InReady, 1'b0);
        chk("bp_head", vif.ALUResult, 64'd1);
        step(1'b1, C_PASS, '0, 64'd3, 1'b0, acc, xf);
        chk("bp_hold_valid", vif.OutValid, 1'b1);
        chk("bp_hold_res", vif.ALUResult, 64'd1);
        op3_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(!op3_done, C_PASS, '0, 64'd3, 1'b1, acc, xf);
            if (acc) op3_done = 1'b1;
        end
        chk("bp_op3_accepted", op3_done, 1'b1);
        chk("bp_count", out_log.size(), 3);
        for (int k = 0; k < out_log.size() && k < 3; k++)
            chk("bp_order", out_log[k], 64'(k + 1));

        // Streaming: one op per cycle in and out.
        n_acc = 0; n_x = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, legal[$urandom_range(0, 4)], {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc, xf);
            n_acc += int'(acc);
            if (i > 0) n_x += int'(xf);
        end
        step(1'b0, '0, '0, '0, 1'b1, acc, xf);
        n_x += int'(xf);
        chk("stream_accepts", n_acc, 100);
        chk("stream_outputs", n_x, 100);
        chk("stream_drained", sb.size(), 0);

        // Reset mid-stream with both OR and SK full.
        step(1'b1, C_ADD, 64'd10, 64'd20, 1'b0, acc, xf);
        step(1'b1, C_SUB, 64'd50, 64'd7, 1'b0, acc, xf);
        step(1'b0, '0, '0, '0, 1'b0, acc, xf);
        chk("pre_rst_full", vif.InReady, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_outvalid", vif.OutValid, 1'b0);
        chk("arst_inready", vif.InReady, 1'b1);
        chk("arst_payload", observed(), '0);
        sb.delete();
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, acc, xf);
            chk("no_stale", vif.OutValid, 1'b0);
        end
        directed("post_rst", C_ADD, 64'd2, 64'd3, 64'd5, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of ALU control; consumes the 4-bit ALU control code plus the two register-file operands.
- Produces the ALU result and NZCV flags one cycle later. Zero feeds CBZ branch resolution.
- Valid/ready handshake on both sides. A one-entry skid buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 64, operand/result width in bits (legal values ≥ 8).

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  upstream has an operation this cycle
- InReady  output  1  stage can accept an operation this cycle
- ALUCtrl  input  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 ORR, 0111 PASS B
- BusA  input  WIDTH  operand A
- BusB  input  WIDTH  operand B
- OutValid  output  1  result/flags valid
- OutReady  input  1  downstream consumes the result this cycle
- ALUResult  output  WIDTH  result
- Zero  output  1  ALUResult == 0
- Negative  output  1  ALUResult[WIDTH-1]
- Carry  output  1  carry flag
- Overflow  output  1  signed overflow flag
- IllegalOp  output  1  the entry's ALUCtrl was not one of the five legal codes

Behaviour:
- Handshake:
  - Input accepted when InValid && InReady.
  - Output transferred when OutValid && OutReady.
  - Output payload is held stable while OutValid && !OutReady.
- Storage: output register (OR) plus skid register (SK), each with its own valid bit.
  - InReady = !SK.valid. InReady is driven from a register only, with no combinational path from OutReady.
- Latency: an accepted op appears on the outputs the next cycle when OR is empty or draining. Throughput is one op per cycle with OutReady held high.
- Per-cycle update, given accept and transfer for the cycle:
  - OR empty or transferring, SK empty: accepted op loads OR.
  - OR empty or transferring, SK full: SK moves to OR and SK empties. No accept is possible this cycle.
  - OR full and held, accept: op loads SK, so InReady = 0 next cycle.
  - Ordering is strictly FIFO. An op is never dropped or duplicated.
- Arithmetic:
  - ADD: {C, R} = A + B (WIDTH+1 bits). V = (A[msb] == B[msb]) && (R[msb] != A[msb]).
  - SUB: {C, R} = A + ~B + 1, so C = 1 means no borrow (A ≥ B unsigned). V = (A[msb] != B[msb]) && (R[msb] != A[msb]).
  - AND, ORR: bitwise; C = 0, V = 0.
  - PASS B: R = B; C = 0, V = 0.
  - Any other ALUCtrl: R = 0, C = 0, V = 0, IllegalOp = 1. The op still flows through the handshake. Zero = 1 for that entry.
  - Z and N are always derived from R. Flags are computed at accept time and stored with the entry.
- Reset (any time, including mid-transfer):
  - All valid bits clear immediately and any buffered ops are discarded.
  - Outputs after reset: OutValid = 0, ALUResult = 0, all flags = 0, IllegalOp = 0, InReady = 1.
  - The first accept can occur on the first rising edge after Reset deasserts.
- Payload outputs are don't-care-stable (they hold their last value) while OutValid = 0. The bench must not check them then.

Test Plan:
- Reset asserted mid-stream with OR and SK both full → OutValid = 0, InReady = 1, ALUResult = 0 asynchronously. Flags are 0 and no stale op emerges after release.
- ADD with A = 0x7FFF_FFFF_FFFF_FFFF, B = 1, OutReady = 1 → one cycle later R = 0x8000_0000_0000_0000, N = 1, V = 1, C = 0, Z = 0.
- SUB with A = 5, B = 5 → R = 0, Z = 1, C = 1. SUB with A = 3, B = 5 → R = 0xFFFF_FFFF_FFFF_FFFE, N = 1, C = 0, V = 0.
- PASS B with B = 0 (CBZ taken) → Z = 1. AND 0xF0 & 0x0F → 0, Z = 1. ORR 0xF0 | 0x0F → 0xFF. ALUCtrl = 1111 → IllegalOp = 1, R = 0.
- Backpressure: issue ops 1, 2, 3 back-to-back with OutReady = 0 → op1 in OR, op2 in SK, InReady = 0 so op3 stalls. Raise OutReady → outputs 1, 2, 3 in order, none lost or duplicated.
- Streaming: 100 random legal ops with InValid = 1, OutReady = 1 → one result per cycle. Each result and its NZCV flags match a reference model.
